video_line_sched: RTL and testbench
===================================

# video_line_sched

Schedules the ping-pong line buffers between the layer renderer and the VGA output timing. It uses the timing generator's `next_frame`, `next_line` and `next_pixel` strobes to decide which line the renderer composes next and into which buffer. It also generates the display-side read address into the other buffer, and flags lines the renderer failed to finish in time. It sits between the video timing block, the renderer and the line-buffer RAMs.

## Interface
Parameters:
- `H_ACTIVE`, default 640: visible pixels per line; read-address span.
- `V_ACTIVE`, default 480: visible lines per frame; render-line span.

Ports. Clock: `clk`. Reset: `rst`, synchronous, active-high.
- `clk`  in  1  video pixel clock.
- `rst`  in  1  synchronous active-high reset.
- `next_frame`  in  1  one-cycle strobe, one line before visible line 0; always coincides with a `next_line`.
- `next_line`  in  1  one-cycle strobe at the last clock of every line.
- `next_pixel`  in  1  pixel-advance enable.
- `render_done`  in  1  one-cycle strobe from the renderer: current line fully written.
- `render_start`  out  1  one-cycle request to compose `render_line` into buffer `render_buf`.
- `render_line`  out  9  line number to compose, 0..V_ACTIVE-1.
- `render_buf`  out  1  buffer index the renderer writes.
- `rd_buf`  out  1  buffer index being displayed; always `~render_buf`.
- `rd_addr`  out  10  pixel read address into `rd_buf`.
- `rd_en`  out  1  displayed pixel valid (RAM read enable / black otherwise).
- `underrun`  out  1  one-cycle strobe: a swap occurred before `render_done`.

## Operation
FSM states:
- IDLE: no render outstanding and no frame in progress. Reset state.
- RENDER: `render_start` has been issued and `render_done` has not yet been seen.
- WAIT: line rendered, waiting for the swap.

Frame start:
- `next_frame` in any state sets `render_line` to 0 and issues `render_start`. The state goes to RENDER.
- `render_buf` is unchanged.
- Any in-progress render is abandoned. No underrun is flagged.

Swap, on `next_line` without `next_frame`, in RENDER or WAIT:
- `render_buf` toggles; `rd_buf` toggles with it.
- `line_valid` (internal) is set to 1 if the state was WAIT, else 0.
- If the state was RENDER, `underrun` pulses.
- If `render_line` < V_ACTIVE-1: `render_line` increments, `render_start` is issued, and the state goes to RENDER.
- Otherwise (last line): the state goes to IDLE.

Other cases:
- `next_line` in IDLE without `next_frame` clears `line_valid`.
- `render_done` in RENDER goes to WAIT. It is ignored in IDLE and WAIT.
- `render_done` in the same cycle as `next_line` counts as on time: no underrun, and `line_valid` is 1.
- `render_start` while the renderer is still busy means abort-and-restart. The renderer must accept it.

Display side:
- `next_line` sets `rd_addr` to 0.
- Each `next_pixel` increments `rd_addr` while `rd_addr` < H_ACTIVE, then it holds at H_ACTIVE.
- `rd_en` = `line_valid` && (`rd_addr` < H_ACTIVE), registered.

## Timing
- Reset values:
  - `render_start`, `render_line`, `render_buf`, `rd_addr`, `rd_en`, `underrun`, `line_valid`: 0.
  - `rd_buf`: 1.
  - State: IDLE.
- `render_start`, `underrun` and the buffer toggle appear 1 cycle after the `next_line`/`next_frame` strobe.
- `rd_addr` = 0 and the new `rd_en` appear 1 cycle after `next_line`.
- `rd_addr` reaches H_ACTIVE after exactly H_ACTIVE `next_pixel` pulses.
- The renderer budget is one full line: from `render_start` to the next `next_line`, inclusive.
- `rst` asserted mid-operation overrides all inputs that cycle. The next `render_start` comes only after `next_frame`.

## Configuration
Macro: `VIDEO_UNDERRUN_CNT_EN`.
- Defined:
  - Adds input `underrun_clr` (1) and output `underrun_cnt` (8).
  - `underrun_cnt` is a saturating count (max 255) of `underrun` pulses. Reset value is 0.
  - `underrun_clr` zeroes the count. Clear wins over a simultaneous increment.
- Undefined: neither port exists. `underrun` strobe behaviour is unchanged.

## Structure
- Shared package `video_pkg`:
  - H_ACTIVE/V_ACTIVE defaults.
  - Line-number and pixel-address widths.
  - FSM state enum (IDLE, RENDER, WAIT).
- Sub-module `video_line_rd_counter`: `rd_addr`/`rd_en` generation from `next_line`, `next_pixel` and `line_valid`.
- The FSM and buffer toggling stay in the top module.

## Test plan
- Reset, then `next_frame`: `render_start`=1 one cycle later, with `render_line`=0, `render_buf`=0, `rd_buf`=1.
- `render_done` 100 cycles after start, then `next_line`: buffers swap (`rd_buf`=0), `render_line`=1, `render_start` pulses, `underrun`=0. After 640 `next_pixel` pulses, `rd_addr` goes 0..639, `rd_en`=1, then `rd_addr`=640 and `rd_en`=0.
- No `render_done` before `next_line`: `underrun`=1 for one cycle, `rd_en` stays 0 for that line, and `render_line` still increments. With the macro, `underrun_cnt`=1.
- `render_done` and `next_line` in the same cycle: no underrun, `rd_en`=1.
- Full frame, each line done early: 480 `render_start` pulses (lines 0..479). The `next_line` after line 479 goes to IDLE with no further start, and `rd_en` stays 0 on the following line.
- `next_frame` while in RENDER at line 200: `render_line`=0, `render_start` pulses, `underrun`=0. With the macro, 256 underruns give `underrun_cnt`=255, and `underrun_clr` gives 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared types and widths for the video line scheduler.
package video_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;
   localparam int unsigned LINE_W       = 9;
   localparam int unsigned ADDR_W       = 10;
   localparam int unsigned CNT_W        = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RENDER = 2'd1,
      WAIT   = 2'd2
   } state_t;

endpackage

// File: rtl/video_line_sched_if.sv
// Scheduler bus: timing strobes, renderer handshake and display read port.
// Optional underrun counter ports appear when VIDEO_UNDERRUN_CNT_EN is defined.
interface video_line_sched_if;
   import video_pkg::*;

   logic              next_frame;
   logic              next_line;
   logic              next_pixel;
   logic              render_done;
   logic              render_start;
   logic [LINE_W-1:0] render_line;
   logic              render_buf;
   logic              rd_buf;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;
   logic              underrun;
`ifdef VIDEO_UNDERRUN_CNT_EN
   logic              underrun_clr;
   logic [CNT_W-1:0]  underrun_cnt;

   modport master (
      output next_frame, next_line, next_pixel, render_done, underrun_clr,
      input  render_start, render_line, render_buf, rd_buf, rd_addr, rd_en,
             underrun, underrun_cnt
   );
   modport slave (
      input  next_frame, next_line, next_pixel, render_done, underrun_clr,
      output render_start, render_line, render_buf, rd_buf, rd_addr, rd_en,
             underrun, underrun_cnt
   );
`else
   modport master (
      output next_frame, next_line, next_pixel, render_done,
      input  render_start, render_line, render_buf, rd_buf, rd_addr, rd_en,
             underrun
   );
   modport slave (
      input  next_frame, next_line, next_pixel, render_done,
      output render_start, render_line, render_buf, rd_buf, rd_addr, rd_en,
             underrun
   );
`endif

endinterface

// File: rtl/video_line_rd_counter.sv
// Display-side pixel read address and read enable for the displayed buffer.
module video_line_rd_counter
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              next_line,
   input  logic              next_pixel,
   input  logic              line_valid,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              rd_en
);

   localparam logic [ADDR_W-1:0] H_END = ADDR_W'(H_ACTIVE);

   logic [ADDR_W-1:0] addr_d;

   always_comb begin
      addr_d = rd_addr;
      if (next_line)
         addr_d = '0;
      else if (next_pixel && (rd_addr < H_END))
         addr_d = rd_addr + ADDR_W'(1);
   end

   // line_valid is the next-cycle value so rd_en lines up with the new address
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr <= '0;
         rd_en   <= 1'b0;
      end else begin
         rd_addr <= addr_d;
         rd_en   <= line_valid && (addr_d < H_END);
      end
   end

endmodule

// File: rtl/video_line_sched.sv
// Ping-pong line-buffer scheduler between video timing, renderer and line RAMs.
// Define VIDEO_UNDERRUN_CNT_EN to add the saturating underrun counter.
module video_line_sched
   import video_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF
) (
   input logic               clk,
   input logic               rst,
   video_line_sched_if.slave bus
);

   localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(V_ACTIVE - 1);

   state_t            state_q, state_d;
   logic              start_q, start_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              rbuf_q, rbuf_d;
   logic              under_q, under_d;
   logic              valid_q, valid_d;
   logic              done_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         line_q  <= '0;
         rbuf_q  <= 1'b0;
         under_q <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         line_q  <= line_d;
         rbuf_q  <= rbuf_d;
         under_q <= under_d;
         valid_q <= valid_d;
      end
   end

   // render_done coinciding with the swap counts as on time
   assign done_now = (state_q == RENDER) && bus.render_done;

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      line_d  = line_q;
      rbuf_d  = rbuf_q;
      under_d = 1'b0;
      valid_d = valid_q;

      if (bus.next_frame) begin
         line_d  = '0;
         start_d = 1'b1;
         valid_d = 1'b0;
         state_d = RENDER;
      end else if (bus.next_line) begin
         case (state_q)
            RENDER, WAIT: begin
               rbuf_d  = ~rbuf_q;
               valid_d = (state_q == WAIT) || done_now;
               under_d = (state_q == RENDER) && !bus.render_done;
               if (line_q < LAST_LINE) begin
                  line_d  = line_q + LINE_W'(1);
                  start_d = 1'b1;
                  state_d = RENDER;
               end else begin
                  state_d = IDLE;
               end
            end
            default: valid_d = 1'b0;
         endcase
      end else if (done_now) begin
         state_d = WAIT;
      end
   end

   assign bus.render_start = start_q;
   assign bus.render_line  = line_q;
   assign bus.render_buf   = rbuf_q;
   assign bus.rd_buf       = ~rbuf_q;
   assign bus.underrun     = under_q;

   video_line_rd_counter #(
      .H_ACTIVE (H_ACTIVE)
   ) u_rd_counter (
      .clk        (clk),
      .rst        (rst),
      .next_line  (bus.next_line),
      .next_pixel (bus.next_pixel),
      .line_valid (valid_d),
      .rd_addr    (bus.rd_addr),
      .rd_en      (bus.rd_en)
   );

`ifdef VIDEO_UNDERRUN_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || bus.underrun_clr)
         cnt_q <= '0;
      else if (under_q && (cnt_q != '1))
         cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.underrun_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_video_line_sched.sv
// Scoreboard bench for video_line_sched: stimulus pushes expectations, a monitor pops them.
module tb_video_line_sched;
   import video_pkg::*;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   video_line_sched_if bus();

   video_line_sched #(
      .H_ACTIVE (640),
      .V_ACTIVE (480)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [8:0] line;
      logic       rbuf;
   } start_t;

   typedef struct packed {
      logic       en;
      logic [9:0] addr;
   } rd_t;

   start_t start_q[$];
   logic   und_q[$];
   rd_t    rd_q[$];

   int   total = 0;
   int   bad   = 0;
   logic pix_ev = 1'b0;
   logic eb;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic exp_start(input int line, input logic rbuf);
      start_q.push_back('{line: 9'(line), rbuf: rbuf});
   endtask

   task automatic exp_rd(input logic en, input int addr);
      rd_q.push_back('{en: en, addr: 10'(addr)});
   endtask

   task automatic exp_und(input logic rbuf);
      und_q.push_back(rbuf);
   endtask

   task automatic step(input logic nf, input logic nl, input logic np, input logic rd);
      bus.next_frame  = nf;
      bus.next_line   = nl;
      bus.next_pixel  = np;
      bus.render_done = rd;
      @(posedge clk);
      #1;
      bus.next_frame  = 1'b0;
      bus.next_line   = 1'b0;
      bus.next_pixel  = 1'b0;
      bus.render_done = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   always @(posedge clk) pix_ev <= !rst && (bus.next_pixel || bus.next_line);

   always @(negedge clk) begin : monitor
      start_t s;
      rd_t    r;
      logic   u;
      if (!rst) begin
         if (bus.render_start) begin
            if (start_q.size() == 0) begin
               check("unexpected_render_start", 1, 0);
            end else begin
               s = start_q.pop_front();
               check("render_line", int'(bus.render_line), int'(s.line));
               check("render_buf", int'(bus.render_buf), int'(s.rbuf));
               check("rd_buf", int'(bus.rd_buf), int'(!s.rbuf));
            end
         end
         if (bus.underrun) begin
            if (und_q.size() == 0) begin
               check("unexpected_underrun", 1, 0);
            end else begin
               u = und_q.pop_front();
               check("underrun_buf", int'(bus.render_buf), int'(u));
            end
         end
         if (pix_ev) begin
            if (rd_q.size() == 0) begin
               check("unexpected_rd_event", 1, 0);
            end else begin
               r = rd_q.pop_front();
               check("rd_en", int'(bus.rd_en), int'(r.en));
               check("rd_addr", int'(bus.rd_addr), int'(r.addr));
            end
         end
      end
   end

   initial begin
      rst             = 1'b1;
      bus.next_frame  = 1'b0;
      bus.next_line   = 1'b0;
      bus.next_pixel  = 1'b0;
      bus.render_done = 1'b0;
`ifdef VIDEO_UNDERRUN_CNT_EN
      bus.underrun_clr = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_render_start", int'(bus.render_start), 0);
      check("reset_render_line", int'(bus.render_line), 0);
      check("reset_render_buf", int'(bus.render_buf), 0);
      check("reset_rd_buf", int'(bus.rd_buf), 1);
      check("reset_rd_addr", int'(bus.rd_addr), 0);
      check("reset_rd_en", int'(bus.rd_en), 0);
      check("reset_underrun", int'(bus.underrun), 0);
`ifdef VIDEO_UNDERRUN_CNT_EN
      check("reset_underrun_cnt", int'(bus.underrun_cnt), 0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // frame start, line 0 into buffer 0
      eb = 1'b0;
      exp_start(0, eb);
      exp_rd(1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(99);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      idle(1);

      // on-time swap, then a full line of pixels
      eb = 1'b1;
      exp_start(1, eb);
      exp_rd(1'b1, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 642; k++) begin
         exp_rd(k < 640, (k < 640) ? k : 640);
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end

      // underrun: line 1 never finished
      eb = 1'b0;
      exp_und(eb);
      exp_start(2, eb);
      exp_rd(1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      exp_rd(1'b0, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      exp_rd(1'b0, 2);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);
`ifdef VIDEO_UNDERRUN_CNT_EN
      check("underrun_cnt_one", int'(bus.underrun_cnt), 1);
`endif

      // render_done coincident with next_line is on time
      eb = 1'b1;
      exp_start(3, eb);
      exp_rd(1'b1, 0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      exp_rd(1'b1, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(2);

      // full frame, every line done early
      exp_start(0, eb);
      exp_rd(1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 480; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         eb = ~eb;
         exp_rd(1'b1, 0);
         if (i < 479) exp_start(i + 1, eb);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1);
      exp_rd(1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      exp_rd(1'b0, 1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      idle(3);

      // next_frame abandons a render in progress at line 200
      exp_start(0, eb);
      exp_rd(1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1);
         eb = ~eb;
         exp_start(i + 1, eb);
         exp_rd(1'b1, 0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      exp_start(0, eb);
      exp_rd(1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      idle(2);

`ifdef VIDEO_UNDERRUN_CNT_EN
      // saturate, clear, then clear against a simultaneous increment
      for (int i = 0; i < 256; i++) begin
         eb = ~eb;
         exp_und(eb);
         exp_start(i + 1, eb);
         exp_rd(1'b0, 0);
         step(1'b0, 1'b1, 1'b0, 1'b0);
      end
      idle(3);
      check("underrun_cnt_sat", int'(bus.underrun_cnt), 255);
      bus.underrun_clr = 1'b1;
      idle(1);
      bus.underrun_clr = 1'b0;
      idle(1);
      check("underrun_cnt_clr", int'(bus.underrun_cnt), 0);
      eb = ~eb;
      exp_und(eb);
      exp_start(257, eb);
      exp_rd(1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      bus.underrun_clr = 1'b1;
      idle(1);
      bus.underrun_clr = 1'b0;
      idle(1);
      check("underrun_cnt_clr_wins", int'(bus.underrun_cnt), 0);
`endif

      // reset mid-render overrides a coincident next_line; no start afterwards
      bus.next_line = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.next_line = 1'b0;
      check("rst_render_buf", int'(bus.render_buf), 0);
      check("rst_rd_buf", int'(bus.rd_buf), 1);
      exp_rd(1'b0, 0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      idle(5);

      check("start_q_drained", start_q.size(), 0);
      check("und_q_drained", und_q.size(), 0);
      check("rd_q_drained", rd_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
